// File: rtl/dmem_latency_responder.sv
// Word-organised data memory behind a valid/ready request port with a one-cycle
// response strobe; read and write wait states are set by parameters.
module dmem_latency_responder #(
    parameter int unsigned DEPTH_WORDS   = 256,
    parameter int unsigned READ_LATENCY  = 2,
    parameter int unsigned WRITE_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    if (READ_LATENCY < 1 || READ_LATENCY > 15) begin : g_bad_read_latency
        $error("dmem_latency_responder: READ_LATENCY must be 1..15");
    end
    if (WRITE_LATENCY < 1 || WRITE_LATENCY > 15) begin : g_bad_write_latency
        $error("dmem_latency_responder: WRITE_LATENCY must be 1..15");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;

    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic        w_accept;
    logic        w_done;
    logic        w_ready_nxt;
    logic        w_err;
    logic        w_commit;
    logic [AW-1:0] w_idx;
    logic [31:0] w_rdata_nxt;

    assign w_idx    = r_addr[AW+1:2];
    assign w_err    = (r_addr[1:0] != 2'b00) || ({2'b00, r_addr[31:2]} >= DEPTH_WORDS);
    assign w_commit = rst && w_done && r_we && !w_err;

    // WAIT completes on the edge where the counter is already 0; that edge raises
    // rsp_valid and req_ready together, so a new request can follow the response.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        w_ready_nxt = 1'b0;
        case (r_state)
            S_IDLE, S_RESP: begin
                w_accept    = req_valid && req_ready;
                w_ready_nxt = !w_accept;
                if (w_accept) begin
                    w_cnt_nxt   = req_we ? 4'(WRITE_LATENCY - 1) : 4'(READ_LATENCY - 1);
                    w_state_nxt = S_WAIT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_done      = 1'b1;
                    w_ready_nxt = 1'b1;
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_rdata_nxt = '0;
        if (w_done && !r_we && !w_err) begin
            w_rdata_nxt = r_mem[w_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            req_ready <= w_ready_nxt;
            rsp_valid <= w_done;
            rsp_rdata <= w_rdata_nxt;
            rsp_err   <= w_done && w_err;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
        end
    end

    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (r_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
